// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural order reorder buffer for the R2^2SDF FFT output, ping-pong banked.
// Define FFT_REORDER_OUT_FF_EN to add one extra output register stage (latency N+2 instead of N+1).
module fft_bitrev_reorder #(
  parameter int data_resolution = 16,
  parameter int fft_pts         = 64
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       sys_en,
  input  logic                       din_sof,
  input  logic [data_resolution-1:0] din_r,
  input  logic [data_resolution-1:0] din_i,
  output logic [data_resolution-1:0] dout_r,
  output logic [data_resolution-1:0] dout_i,
  output logic                       dout_valid,
  output logic                       dout_sof,
  output logic                       sync_err
);

  localparam int addr_w = $clog2(fft_pts);
  localparam int word_w = 2 * data_resolution;
  localparam logic [addr_w-1:0] last_idx = addr_w'(fft_pts - 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  function automatic logic [addr_w-1:0] bitrev(input logic [addr_w-1:0] a);
    logic [addr_w-1:0] r;
    for (int i = 0; i < addr_w; i++) r[i] = a[addr_w-1-i];
    return r;
  endfunction

  state_t             state;
  logic [addr_w-1:0]  wr_cnt;
  logic [addr_w-1:0]  rd_cnt;
  logic               wr_bank;
  logic [word_w-1:0]  mem [2][fft_pts];
  logic [word_w-1:0]  rd_data;
  logic               rd_valid;
  logic               rd_sof;

  logic               realign;
  logic               wr_en;
  logic               frame_done;
  logic [addr_w-1:0]  wr_addr;

  // A din_sof off the expected frame boundary restarts the frame at position 0 in the same bank.
  always_comb begin
    realign    = sys_en && din_sof && (state != IDLE) && (wr_cnt != '0);
    wr_en      = sys_en && ((state != IDLE) || din_sof);
    wr_addr    = realign ? '0 : bitrev(wr_cnt);
    frame_done = wr_en && !realign && (wr_cnt == last_idx);
  end

  // NOTE: the banks carry no reset so they map onto plain RAM; stale contents are never marked valid.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_bank][wr_addr] <= {din_r, din_i};
    if (sys_en && state == STREAM) rd_data <= mem[~wr_bank][rd_cnt];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      wr_bank  <= 1'b0;
      rd_valid <= 1'b0;
      rd_sof   <= 1'b0;
      sync_err <= 1'b0;
    end else if (sys_en) begin
      rd_valid <= (state == STREAM);
      rd_sof   <= (state == STREAM) && (rd_cnt == '0);
      if (frame_done)            rd_cnt <= '0;
      else if (state == STREAM)  rd_cnt <= rd_cnt + addr_w'(1);
      case (state)
        IDLE: begin
          if (din_sof) begin
            wr_cnt <= addr_w'(1);
            state  <= FILL;
          end
        end
        default: begin
          if (realign) begin
            sync_err <= 1'b1;
            wr_cnt   <= addr_w'(1);
          end else begin
            wr_cnt <= wr_cnt + addr_w'(1);
            if (frame_done) begin
              wr_bank <= ~wr_bank;
              state   <= STREAM;
            end
          end
        end
      endcase
    end
  end

  // Stage flags hold across sys_en gaps; en_q blanks the visible strobes on gap cycles.
  logic [word_w-1:0] q_data;
  logic              q_valid;
  logic              q_sof;
  logic              en_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      q_data  <= '0;
      q_valid <= 1'b0;
      q_sof   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      en_q <= sys_en;
      if (sys_en) begin
        q_valid <= rd_valid;
        q_sof   <= rd_valid && rd_sof;
        if (rd_valid) q_data <= rd_data;
      end
    end
  end

`ifdef FFT_REORDER_OUT_FF_EN
  logic [word_w-1:0] o_data;
  logic              o_valid;
  logic              o_sof;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      o_data  <= '0;
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
    end else if (sys_en) begin
      o_valid <= q_valid;
      o_sof   <= q_sof;
      if (q_valid) o_data <= q_data;
    end
  end

  assign {dout_r, dout_i} = o_data;
  assign dout_valid       = o_valid && en_q;
  assign dout_sof         = o_sof && en_q;
`else
  assign {dout_r, dout_i} = q_data;
  assign dout_valid       = q_valid && en_q;
  assign dout_sof         = q_sof && en_q;
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder at N=16: single frame, back-to-back, gaps, resync, reset.
module tb_fft_bitrev_reorder;

  localparam int dw = 16;
  localparam int n  = 16;
`ifdef FFT_REORDER_OUT_FF_EN
  localparam int lat = n + 2;
`else
  localparam int lat = n + 1;
`endif

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          sys_en;
  logic          din_sof;
  logic [dw-1:0] din_r;
  logic [dw-1:0] din_i;
  logic [dw-1:0] dout_r;
  logic [dw-1:0] dout_i;
  logic          dout_valid;
  logic          dout_sof;
  logic          sync_err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int in_r;
    int exp_r;
  } vec_t;

  vec_t tab [n];
  int   seq [n];

  always #5 sys_clk = ~sys_clk;

  fft_bitrev_reorder #(
    .data_resolution(dw),
    .fft_pts        (n)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .sys_en    (sys_en),
    .din_sof   (din_sof),
    .din_r     (din_r),
    .din_i     (din_i),
    .dout_r    (dout_r),
    .dout_i    (dout_i),
    .dout_valid(dout_valid),
    .dout_sof  (dout_sof),
    .sync_err  (sync_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of input, then sample outputs 1 time unit after the edge.
  task automatic drive(input logic en, input logic sof, input int val);
    sys_en  = en;
    din_sof = sof;
    din_r   = dw'(val);
    din_i   = dw'(-val);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    drive(1'b0, 1'b0, 0);
    sys_rst = 1'b0;
  endtask

  task automatic check_zero(input string name);
    check({name, "_r"},     dout_r,     0);
    check({name, "_i"},     dout_i,     0);
    check({name, "_valid"}, dout_valid, 0);
    check({name, "_sof"},   dout_sof,   0);
    check({name, "_err"},   sync_err,   0);
  endtask

  // o < 0: no output expected; otherwise output index o of a frame whose inputs were base+p.
  task automatic expect_out(input string name, input int o, input int base);
    logic [dw-1:0] er;
    logic [dw-1:0] ei;
    if (o < 0) begin
      check({name, "_idle_valid"}, dout_valid, 0);
    end else begin
      er = dw'(base + tab[o].exp_r);
      ei = dw'(-(base + tab[o].exp_r));
      check({name, "_valid"}, dout_valid, 1);
      check({name, "_sof"},   dout_sof,   (o == 0) ? 1 : 0);
      check({name, "_r"},     dout_r,     er);
      check({name, "_i"},     dout_i,     ei);
    end
  endtask

  // Three back-to-back frames (din_r = active index); gap_pct of cycles drop sys_en.
  task automatic run_stream(input string name, input int gap_pct);
    int            a;
    int            o;
    logic [dw-1:0] last_r;
    a      = 0;
    last_r = '0;
    do_reset();
    for (int c = 0; c < 3000 && a < lat + 3 * n; c++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        drive(1'b0, 1'b1, 5000 + c);
        check({name, "_gap_valid"}, dout_valid, 0);
        check({name, "_gap_sof"},   dout_sof,   0);
        check({name, "_gap_hold"},  dout_r,     last_r);
      end else begin
        drive(1'b1, (a < 3 * n) && (a % n == 0), a);
        if (a < lat) begin
          expect_out(name, -1, 0);
        end else begin
          o = a - lat;
          expect_out(name, o % n, n * (o / n));
          last_r = dw'(n * (o / n) + tab[o % n].exp_r);
        end
        a++;
      end
    end
    check({name, "_budget"}, a, lat + 3 * n);
  endtask

  initial begin
    seq = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    for (int p = 0; p < n; p++) begin
      tab[p].in_r  = p;
      tab[p].exp_r = seq[p];
    end

    sys_rst = 1'b1;
    sys_en  = 1'b0;
    din_sof = 1'b0;
    din_r   = '0;
    din_i   = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    check_zero("reset");
    sys_rst = 1'b0;

    // Single frame: table inputs, then the reordered table out starting at active cycle lat.
    for (int a = 0; a < lat + n; a++) begin
      if (a < n) drive(1'b1, a == 0, tab[a].in_r);
      else       drive(1'b1, 1'b0, 0);
      expect_out("single", a - lat, 0);
    end

    run_stream("b2b", 0);
    run_stream("gaps", 30);

    // Mid-frame din_sof at position 5 of frame 2; restarted frame carries 100+p.
    do_reset();
    for (int a = 0; a < 21 + lat + n; a++) begin
      if (a < n)       drive(1'b1, a == 0, a);
      else if (a < 21) drive(1'b1, a == n, a);
      else if (a < 37) drive(1'b1, a == 21, 100 + a - 21);
      else             drive(1'b1, 1'b0, 999);
      if (a < lat)                          expect_out("sync_f1", -1, 0);
      else if (a < lat + n)                 expect_out("sync_f1", a - lat, 0);
      else if (a >= 21 + lat)               expect_out("sync_f2", a - 21 - lat, 100);
      if (a == 20)                          check("sync_err_early", sync_err, 0);
      if (a >= 21)                          check("sync_err_set", sync_err, 1);
    end
    sys_rst = 1'b1;
    drive(1'b1, 1'b0, 0);
    sys_rst = 1'b0;
    check_zero("rst_stream");

    // Reset at position 9 of frame 1, then no output until a fresh din_sof.
    do_reset();
    for (int a = 0; a < 9; a++) drive(1'b1, a == 0, a);
    sys_rst = 1'b1;
    drive(1'b1, 1'b0, 9);
    sys_rst = 1'b0;
    check_zero("rst_mid");
    for (int c = 0; c < 2 * lat + 4; c++) begin
      drive(1'b1, 1'b0, 300 + c);
      check("rst_nosof_valid", dout_valid, 0);
    end
    for (int a = 0; a < lat + n; a++) begin
      if (a < n) drive(1'b1, a == 0, 200 + a);
      else       drive(1'b1, 1'b0, 0);
      expect_out("rst_new", a - lat, 200);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
